// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and control-bundle constants for the pipeline hazard sequencer.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_flush;
    logic ex_mem_we;
    logic mem_wb_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN = '{
    pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0, id_ex_we: 1'b1,
    id_ex_flush: 1'b0, ex_mem_we: 1'b1, mem_wb_flush: 1'b0
  };

  // Whole pipeline held; MEM/WB gets a bubble so a stalled access never retires twice.
  localparam pipe_ctrl_t CTRL_FREEZE = '{
    pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0, id_ex_we: 1'b0,
    id_ex_flush: 1'b0, ex_mem_we: 1'b0, mem_wb_flush: 1'b1
  };

  localparam pipe_ctrl_t CTRL_BRANCH = '{
    pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1, id_ex_we: 1'b1,
    id_ex_flush: 1'b1, ex_mem_we: 1'b1, mem_wb_flush: 1'b0
  };

  localparam pipe_ctrl_t CTRL_LOAD_USE = '{
    pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0, id_ex_we: 1'b1,
    id_ex_flush: 1'b1, ex_mem_we: 1'b1, mem_wb_flush: 1'b0
  };

  localparam pipe_ctrl_t CTRL_RESET = '{
    pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b1, id_ex_we: 1'b0,
    id_ex_flush: 1'b1, ex_mem_we: 1'b0, mem_wb_flush: 1'b1
  };

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the sources read in ID.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_id,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_id,
  input  logic                  i_rs1_used_id,
  input  logic                  i_rs2_used_id,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_ex,
  input  logic                  i_mem_read_ex,
  output logic                  o_lu_stall
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit  = i_rs1_used_id && (i_rd_addr_ex == i_rs1_addr_id);
  assign w_rs2_hit  = i_rs2_used_id && (i_rd_addr_ex == i_rs2_addr_id);
  // x0 is hardwired, so a load targeting it never creates a dependency.
  assign o_lu_stall = i_mem_read_ex && (i_rd_addr_ex != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubble, branch flush, memory freeze.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_id,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_id,
  input  logic                  i_rs1_used_id,
  input  logic                  i_rs2_used_id,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_ex,
  input  logic                  i_mem_read_ex,
  input  logic                  i_branch_taken_ex,
  input  logic                  i_dmem_req_mem,
  input  logic                  i_dmem_ready_mem,
  output logic                  o_pc_write_en,
  output logic                  o_if_id_write_en,
  output logic                  o_if_id_flush,
  output logic                  o_id_ex_write_en,
  output logic                  o_id_ex_flush,
  output logic                  o_ex_mem_write_en,
  output logic                  o_mem_wb_flush,
  output logic                  o_mem_timeout_err,
  output logic [1:0]            o_ctrl_state,
  output logic [CNT_W-1:0]      o_stall_cycles,
  output logic [CNT_W-1:0]      o_flush_count
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit WDOG_EN = (MEM_TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  ctrl_state_e       r_state;
  ctrl_state_e       w_state_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_next;
  logic              w_mem_stall;
  logic              w_frozen;
  logic              w_lu_stall;
  pipe_ctrl_t        w_ctrl;

  load_use_detect u_load_use_detect (
    .i_rs1_addr_id (i_rs1_addr_id),
    .i_rs2_addr_id (i_rs2_addr_id),
    .i_rs1_used_id (i_rs1_used_id),
    .i_rs2_used_id (i_rs2_used_id),
    .i_rd_addr_ex  (i_rd_addr_ex),
    .i_mem_read_ex (i_mem_read_ex),
    .o_lu_stall    (w_lu_stall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_mem_stall     = 1'b0;
    unique case (r_state)
      RUN: begin
        if (i_dmem_req_mem && !i_dmem_ready_mem) w_mem_stall = 1'b1;
      end
      MEM_WAIT: begin
        if (!i_dmem_ready_mem) begin
          w_mem_stall = 1'b1;
        end else begin
          w_state_next    = RUN;
          w_wait_cnt_next = '0;
        end
      end
      ERR: begin
        w_state_next = ERR;
      end
      default: begin
        w_state_next    = RUN;
        w_wait_cnt_next = '0;
      end
    endcase
    if (w_mem_stall) begin
      w_state_next = MEM_WAIT;
      if (r_wait_cnt != '1) w_wait_cnt_next = r_wait_cnt + 1'b1;
      if (WDOG_EN && (r_wait_cnt == WAIT_LAST)) w_state_next = ERR;
    end
  end

  assign w_frozen = w_mem_stall || (r_state == ERR);

  // A frozen branch stays in EX and is acted on in the release cycle.
  always_comb begin
    w_ctrl = CTRL_RUN;
    if (!rst_n) begin
      w_ctrl = CTRL_RESET;
    end else if (w_frozen) begin
      w_ctrl = CTRL_FREEZE;
    end else if (i_branch_taken_ex) begin
      w_ctrl = CTRL_BRANCH;
    end else if (w_lu_stall) begin
      w_ctrl = CTRL_LOAD_USE;
    end
  end

  assign o_pc_write_en     = w_ctrl.pc_we;
  assign o_if_id_write_en  = w_ctrl.if_id_we;
  assign o_if_id_flush     = w_ctrl.if_id_flush;
  assign o_id_ex_write_en  = w_ctrl.id_ex_we;
  assign o_id_ex_flush     = w_ctrl.id_ex_flush;
  assign o_ex_mem_write_en = w_ctrl.ex_mem_we;
  assign o_mem_wb_flush    = w_ctrl.mem_wb_flush;
  assign o_mem_timeout_err = rst_n && (r_state == ERR);
  assign o_ctrl_state      = r_state;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_ctrl.pc_we && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (!w_frozen && i_branch_taken_ex && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign o_stall_cycles = r_stall_cnt;
  assign o_flush_count  = r_flush_cnt;
`else
  assign o_stall_cycles = '0;
  assign o_flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven bench for pipeline_hazard_ctrl with an expected-output queue and counter model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W = 8;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush, err, state}
  localparam logic [9:0] E_RUN  = 10'b1101010000;
  localparam logic [9:0] E_RUNW = 10'b1101010001;
  localparam logic [9:0] E_LU   = 10'b0001110000;
  localparam logic [9:0] E_BR   = 10'b1111110000;
  localparam logic [9:0] E_BRW  = 10'b1111110001;
  localparam logic [9:0] E_FRZ0 = 10'b0000001000;
  localparam logic [9:0] E_FRZ1 = 10'b0000001001;
  localparam logic [9:0] E_ERR  = 10'b0000001110;
  localparam logic [9:0] E_RST  = 10'b0010101000;

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic       rs1u;
    logic [4:0] rs2;
    logic       rs2u;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       req;
    logic       rdy;
    logic [9:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs1_addr_id = '0, rs2_addr_id = '0, rd_addr_ex = '0;
  logic rs1_used_id = 1'b0, rs2_used_id = 1'b0, mem_read_ex = 1'b0;
  logic branch_taken_ex = 1'b0, dmem_req_mem = 1'b0, dmem_ready_mem = 1'b0;
  logic pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en, id_ex_flush;
  logic ex_mem_write_en, mem_wb_flush, mem_timeout_err;
  logic [1:0] ctrl_state;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  logic [9:0]       exp_q[$];
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;
  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_rs1_addr_id     (rs1_addr_id),
    .i_rs2_addr_id     (rs2_addr_id),
    .i_rs1_used_id     (rs1_used_id),
    .i_rs2_used_id     (rs2_used_id),
    .i_rd_addr_ex      (rd_addr_ex),
    .i_mem_read_ex     (mem_read_ex),
    .i_branch_taken_ex (branch_taken_ex),
    .i_dmem_req_mem    (dmem_req_mem),
    .i_dmem_ready_mem  (dmem_ready_mem),
    .o_pc_write_en     (pc_write_en),
    .o_if_id_write_en  (if_id_write_en),
    .o_if_id_flush     (if_id_flush),
    .o_id_ex_write_en  (id_ex_write_en),
    .o_id_ex_flush     (id_ex_flush),
    .o_ex_mem_write_en (ex_mem_write_en),
    .o_mem_wb_flush    (mem_wb_flush),
    .o_mem_timeout_err (mem_timeout_err),
    .o_ctrl_state      (ctrl_state),
    .o_stall_cycles    (stall_cycles),
    .o_flush_count     (flush_count)
  );

  function automatic vec_t mk(string n, logic [4:0] rs1, logic rs1u, logic [4:0] rs2,
                              logic rs2u, logic [4:0] rd, logic mr, logic br, logic req,
                              logic rdy, logic [9:0] e);
    vec_t v;
    v.name = n; v.rs1 = rs1; v.rs1u = rs1u; v.rs2 = rs2; v.rs2u = rs2u; v.rd = rd;
    v.mr = mr; v.br = br; v.req = req; v.rdy = rdy; v.exp = e;
    return v;
  endfunction

  // Compare outputs and counters against the oldest queued expectation.
  task automatic check_now(input string name, input logic br);
    logic [9:0] got, e;
    got = {pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en, id_ex_flush,
           ex_mem_write_en, mem_wb_flush, mem_timeout_err, ctrl_state};
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s: outputs got %b required %b", name, got, e);
    end
    n_vec++;
    if (stall_cycles !== m_stall || flush_count !== m_flush) begin
      n_err++;
      $display("FAIL %s counters: got stall=%0d flush=%0d required stall=%0d flush=%0d",
               name, stall_cycles, flush_count, m_stall, m_flush);
    end
    if (PERF && rst_n) begin
      if (!e[9] && m_stall != '1) m_stall++;
      if (br && e[4] && m_flush != '1) m_flush++;
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    rs1_addr_id = v.rs1; rs1_used_id = v.rs1u; rs2_addr_id = v.rs2; rs2_used_id = v.rs2u;
    rd_addr_ex = v.rd; mem_read_ex = v.mr; branch_taken_ex = v.br;
    dmem_req_mem = v.req; dmem_ready_mem = v.rdy;
    exp_q.push_back(v.exp);
    #2;
    check_now(v.name, v.br);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    //            name          rs1 u  rs2 u  rd  mr br rq rdy exp
    tbl.push_back(mk("idle",      0, 0,  0, 0,  0, 0, 0, 0, 0, E_RUN));
    tbl.push_back(mk("lu_rs1",    5, 1,  7, 1,  5, 1, 0, 0, 0, E_LU));
    tbl.push_back(mk("lu_after",  5, 1,  7, 1,  9, 0, 0, 0, 0, E_RUN));
    tbl.push_back(mk("lu_rd0",    0, 1,  0, 1,  0, 1, 0, 0, 0, E_RUN));
    tbl.push_back(mk("rs2_unused",3, 1,  6, 0,  6, 1, 0, 0, 0, E_RUN));
    tbl.push_back(mk("lu_rs2",    3, 1,  6, 1,  6, 1, 0, 0, 0, E_LU));
    tbl.push_back(mk("rs1_unused",6, 0,  2, 1,  6, 1, 0, 0, 0, E_RUN));
    tbl.push_back(mk("no_load",   5, 1,  5, 1,  5, 0, 0, 0, 0, E_RUN));
    tbl.push_back(mk("br_lu",     5, 1,  0, 0,  5, 1, 1, 0, 0, E_BR));
    tbl.push_back(mk("br_only",   1, 1,  2, 1,  3, 0, 1, 0, 0, E_BR));
    tbl.push_back(mk("mem_hit",   1, 1,  2, 1,  3, 0, 0, 1, 1, E_RUN));
    tbl.push_back(mk("mem_hit_lu",8, 1,  2, 1,  8, 1, 0, 1, 1, E_LU));
    // Memory wait of three cycles, released on the fourth.
    tbl.push_back(mk("mw_1",      0, 0,  0, 0,  0, 0, 0, 1, 0, E_FRZ0));
    tbl.push_back(mk("mw_2",      0, 0,  0, 0,  0, 0, 0, 1, 0, E_FRZ1));
    tbl.push_back(mk("mw_3",      0, 0,  0, 0,  0, 0, 0, 1, 0, E_FRZ1));
    tbl.push_back(mk("mw_rel",    0, 0,  0, 0,  0, 0, 0, 1, 1, E_RUNW));
    tbl.push_back(mk("mw_run",    0, 0,  0, 0,  0, 0, 0, 0, 0, E_RUN));
    // Branch held across a two-cycle freeze flushes only on release.
    tbl.push_back(mk("bf_1",      4, 1,  0, 0,  4, 1, 1, 1, 0, E_FRZ0));
    tbl.push_back(mk("bf_2",      4, 1,  0, 0,  4, 1, 1, 1, 0, E_FRZ1));
    tbl.push_back(mk("bf_rel",    4, 1,  0, 0,  4, 1, 1, 1, 1, E_BRW));
    tbl.push_back(mk("bf_run",    0, 0,  0, 0,  0, 0, 0, 0, 0, E_RUN));

    #2;
    exp_q.push_back(E_RST);
    check_now("reset", 1'b0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Watchdog: ready never arrives, ERR after four frozen cycles, ready then ignored.
    step(mk("wd_1", 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ0));
    step(mk("wd_2", 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ1));
    step(mk("wd_3", 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ1));
    step(mk("wd_4", 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ1));
    step(mk("wd_err", 0, 0, 0, 0, 0, 0, 0, 1, 0, E_ERR));
    step(mk("wd_err_rdy", 0, 0, 0, 0, 0, 0, 0, 1, 1, E_ERR));
    step(mk("wd_err_br", 0, 0, 0, 0, 0, 0, 1, 0, 1, E_ERR));

    // Asynchronous reset while in ERR, checked with the clock low.
    @(negedge clk);
    branch_taken_ex = 1'b0;
    rst_n = 1'b0;
    m_stall = '0;
    m_flush = '0;
    #2;
    exp_q.push_back(E_RST);
    check_now("reset_in_err", 1'b0);
    #1 rst_n = 1'b1;
    step(mk("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));

    // Long load-use hold drives the stall counter into saturation.
    for (int i = 0; i < 300; i++) step(mk("lu_sat", 5, 1, 0, 0, 5, 1, 0, 0, 0, E_LU));
    step(mk("lu_sat_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
    n_vec++;
    if (stall_cycles !== (PERF ? {CNT_W{1'b1}} : {CNT_W{1'b0}})) begin
      n_err++;
      $display("FAIL stall_saturate: got %0d", stall_cycles);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
